// File: rtl/button_bounce_gen.sv
// Emulated noisy push-button: press bounce burst, stable hold, release bounce burst, one-cycle done.
// Outputs are registered and follow the accepting edge by one cycle; start is ignored unless idle.
module button_bounce_gen #(
    parameter int          BOUNCES      = 2,
    parameter int          GLITCH_W     = 2,
    parameter int          FIXED_GLITCH = 0,
    parameter int          HOLD_W       = 16,
    parameter logic [7:0]  SEED         = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    output logic              o_button,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_HOLD,
        S_RELEASE,
        S_FIN
    } state_t;

    localparam int FG_W  = $clog2(FIXED_GLITCH + 1);
    localparam int SEG_W = (FG_W > GLITCH_W + 1) ? FG_W : GLITCH_W + 1;
    localparam int IDX_W = $clog2(2 * BOUNCES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * BOUNCES - 1);

    state_t            r_state;
    logic [SEG_W-1:0]  r_seg_cnt;
    logic [IDX_W-1:0]  r_seg_idx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [7:0]        r_lfsr;
    logic              r_button;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [SEG_W-1:0]  w_seg_cnt_nxt;
    logic [IDX_W-1:0]  w_seg_idx_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [7:0]        w_lfsr_nxt;
    logic [7:0]        w_lfsr_step;
    logic [SEG_W-1:0]  w_g;
    logic              w_button_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    // The LFSR only moves when a segment length is consumed from it.
    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_g = (FIXED_GLITCH != 0) ? SEG_W'(FIXED_GLITCH)
                                     : SEG_W'(r_lfsr[GLITCH_W-1:0]) + SEG_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_seg_cnt  <= '0;
            r_seg_idx  <= '0;
            r_hold_cnt <= '0;
            r_lfsr     <= SEED;
            r_button   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seg_cnt  <= w_seg_cnt_nxt;
            r_seg_idx  <= w_seg_idx_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_button   <= w_button_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_seg_cnt_nxt  = r_seg_cnt;
        w_seg_idx_nxt  = r_seg_idx;
        w_hold_cnt_nxt = r_hold_cnt;
        w_lfsr_nxt     = r_lfsr;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // Hold count is captured here and only touched again in HOLD.
                    w_hold_cnt_nxt = (i_hold_cycles == '0) ? HOLD_W'(1) : i_hold_cycles;
                    if (BOUNCES > 0) begin
                        w_state_nxt   = S_PRESS;
                        w_seg_idx_nxt = '0;
                        w_seg_cnt_nxt = w_g;
                        w_lfsr_nxt    = w_lfsr_step;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_PRESS, S_RELEASE: begin
                if (r_seg_cnt == SEG_W'(1)) begin
                    if (r_seg_idx == LAST_IDX) begin
                        w_state_nxt = (r_state == S_PRESS) ? S_HOLD : S_FIN;
                    end else begin
                        w_seg_idx_nxt = r_seg_idx + IDX_W'(1);
                        w_seg_cnt_nxt = w_g;
                        w_lfsr_nxt    = w_lfsr_step;
                    end
                end else begin
                    w_seg_cnt_nxt = r_seg_cnt - SEG_W'(1);
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_W'(1)) begin
                    if (BOUNCES > 0) begin
                        w_state_nxt   = S_RELEASE;
                        w_seg_idx_nxt = '0;
                        w_seg_cnt_nxt = w_g;
                        w_lfsr_nxt    = w_lfsr_step;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        w_button_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        case (w_state_nxt)
            S_PRESS: begin
                w_button_nxt = ~w_seg_idx_nxt[0];
                w_busy_nxt   = 1'b1;
            end
            S_HOLD: begin
                w_button_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end
            S_RELEASE: begin
                w_button_nxt = w_seg_idx_nxt[0];
                w_busy_nxt   = 1'b1;
            end
            S_FIN:   w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    assign o_button = r_button;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: fixed-glitch, clean-edge and LFSR-driven instances
// checked cycle by cycle against waveforms built from the sequence rules.
module tb_button_bounce_gen;

    logic        clk;
    logic        rst;
    logic [2:0]  st;
    logic [15:0] hc [3];
    logic [2:0]  btn;
    logic [2:0]  bsy;
    logic [2:0]  dn;

    int          total;
    int          bad;
    bit          exp_q[$];
    logic [7:0]  m_lfsr;

    typedef struct {
        int          k;
        logic [15:0] h;
        int          restart;
        int          exp_busy;
    } vec_t;

    vec_t tbl [8];

    button_bounce_gen #(.BOUNCES(2), .GLITCH_W(2), .FIXED_GLITCH(2), .HOLD_W(16), .SEED(8'hA5)) dut_f (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_hold_cycles(hc[0]),
        .o_button(btn[0]), .o_busy(bsy[0]), .o_done(dn[0]));

    button_bounce_gen #(.BOUNCES(0), .GLITCH_W(2), .FIXED_GLITCH(0), .HOLD_W(16), .SEED(8'hA5)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_hold_cycles(hc[1]),
        .o_button(btn[1]), .o_busy(bsy[1]), .o_done(dn[1]));

    button_bounce_gen #(.BOUNCES(2), .GLITCH_W(2), .FIXED_GLITCH(0), .HOLD_W(16), .SEED(8'hA5)) dut_r (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_hold_cycles(hc[2]),
        .o_button(btn[2]), .o_busy(bsy[2]), .o_done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Segment length drawn from the reference LFSR (or the fixed glitch width).
    function automatic int seg_len(input int k);
        int g;
        if (k == 0) return 2;
        g = int'(m_lfsr[1:0]) + 1;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        return g;
    endfunction

    task automatic build(input int k, input logic [15:0] h);
        int nb;
        int hh;
        int g;
        exp_q.delete();
        nb = (k == 1) ? 0 : 2;
        hh = (h == 16'd0) ? 1 : int'(h);
        for (int s = 0; s < 2 * nb; s++) begin
            g = seg_len(k);
            repeat (g) exp_q.push_back(s % 2 == 0);
        end
        repeat (hh) exp_q.push_back(1'b1);
        for (int s = 0; s < 2 * nb; s++) begin
            g = seg_len(k);
            repeat (g) exp_q.push_back(s % 2 == 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 8'hA5;
    endtask

    // One start pulse on instance k; compares every busy cycle, FIN and the idle cycle after.
    task automatic run_seq(input int k, input logic [15:0] h, input int restart_at,
                           input int rst_at, input bit wiggle, input int exp_busy);
        int n;
        int busy_cnt;
        busy_cnt = 0;
        build(k, h);
        n = exp_q.size();
        st[k] = 1'b1;
        hc[k] = h;
        @(negedge clk);
        st[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("btn k%0d cyc%0d", k, i), btn[k], exp_q[i]);
            chk($sformatf("busy k%0d cyc%0d", k, i), bsy[k], 1);
            chk($sformatf("early_done k%0d cyc%0d", k, i), dn[k], 0);
            if (bsy[k]) busy_cnt++;
            if (i + 1 == rst_at) begin
                do_reset();
                chk("rst_btn", btn[k], 0);
                chk("rst_busy", bsy[k], 0);
                chk("rst_done", dn[k], 0);
                @(negedge clk);
                chk("rst_no_late_done", dn[k], 0);
                chk("rst_stays_idle", bsy[k], 0);
                return;
            end
            st[k] = (i + 1 == restart_at);
            if (wiggle) hc[k] = 16'($urandom);
            @(negedge clk);
        end
        st[k] = 1'b0;
        chk($sformatf("fin_btn k%0d", k), btn[k], 0);
        chk($sformatf("fin_busy k%0d", k), bsy[k], 0);
        chk($sformatf("fin_done k%0d", k), dn[k], 1);
        if (exp_busy >= 0) chk($sformatf("busy_len k%0d", k), busy_cnt, exp_busy);
        @(negedge clk);
        chk($sformatf("post_done k%0d", k), dn[k], 0);
        chk($sformatf("post_busy k%0d", k), bsy[k], 0);
        chk($sformatf("post_btn k%0d", k), btn[k], 0);
    endtask

    initial begin
        logic [15:0] rh  [6];
        int          gap [6];
        logic [15:0] h;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        st    = 3'b000;
        for (int k = 0; k < 3; k++) hc[k] = 16'd0;
        m_lfsr = 8'hA5;

        tbl[0] = '{0, 16'd5,  0, 21};
        tbl[1] = '{0, 16'd5,  4, 21};
        tbl[2] = '{0, 16'd0,  0, 17};
        tbl[3] = '{0, 16'd1,  0, 17};
        tbl[4] = '{0, 16'd3,  7, 19};
        tbl[5] = '{0, 16'd12, 0, 28};
        tbl[6] = '{1, 16'd0,  0, 1};
        tbl[7] = '{1, 16'd3,  2, 3};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("idle_btn k%0d", k), btn[k], 0);
                chk($sformatf("idle_busy k%0d", k), bsy[k], 0);
                chk($sformatf("idle_done k%0d", k), dn[k], 0);
            end
        end
        chk("lfsr_hold", dut_r.r_lfsr, 8'hA5);

        for (int t = 0; t < 8; t++)
            run_seq(tbl[t].k, tbl[t].h, tbl[t].restart, 0, tbl[t].restart != 0, tbl[t].exp_busy);

        // Reset during HOLD abandons the sequence; the next start replays it in full.
        run_seq(0, 16'd5, 0, 10, 1'b0, -1);
        run_seq(0, 16'd5, 0, 0, 1'b0, 21);

        for (int j = 0; j < 4; j++) begin
            h = 16'($urandom_range(0, 9));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_seq(0, h, int'($urandom_range(0, 6)), 0, 1'b1, 16 + ((h == 16'd0) ? 1 : int'(h)));
        end

        for (int j = 0; j < 6; j++) begin
            rh[j]  = 16'($urandom_range(0, 6));
            gap[j] = int'($urandom_range(0, 3));
        end
        // Two runs of the LFSR instance from reset must both follow the same reference stream.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int j = 0; j < 6; j++) begin
                repeat (gap[j]) @(negedge clk);
                run_seq(2, rh[j], (j % 2 == 1) ? 3 : 0, 0, 1'b1, -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
